// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: requester-side and controller-side signal bundle for sdram_arbiter.
interface sdram_arbiter_if #(
  parameter int N_REQ    = 4,
  parameter int RD_DEPTH = 8
);
  logic [N_REQ-1:0]          req_read;
  logic [N_REQ-1:0]          req_write;
  logic [N_REQ*26-1:0]       req_addr;
  logic [N_REQ*2-1:0]        req_wr_strb;
  logic [N_REQ*16-1:0]       req_data_write;
  logic [N_REQ-1:0]          req_ready;
  logic [15:0]               rsp_data;
  logic [N_REQ-1:0]          rsp_val;
  logic                      mem_read;
  logic                      mem_write;
  logic [25:0]               mem_addr;
  logic [1:0]                mem_wr_strb;
  logic [15:0]               mem_data_write;
  logic                      mem_cmd_ready;
  logic [15:0]               mem_data_read;
  logic                      mem_data_read_val;
  logic [$clog2(RD_DEPTH):0] outstanding;
  logic                      err_orphan;
  modport slave (
    input  req_read, req_write, req_addr, req_wr_strb, req_data_write,
           mem_cmd_ready, mem_data_read, mem_data_read_val,
    output req_ready, rsp_data, rsp_val, mem_read, mem_write, mem_addr,
           mem_wr_strb, mem_data_write, outstanding, err_orphan
  );
  modport master (
    output req_read, req_write, req_addr, req_wr_strb, req_data_write,
           mem_cmd_ready, mem_data_read, mem_data_read_val,
    input  req_ready, rsp_data, rsp_val, mem_read, mem_write, mem_addr,
           mem_wr_strb, mem_data_write, outstanding, err_orphan
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin sharing of one SDRAM command port, with an in-order read tag FIFO.
module sdram_arbiter #(
  parameter int N_REQ    = 4,
  parameter int RD_DEPTH = 8
) (
  input logic            clk,
  input logic            reset,
  sdram_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int PW   = $clog2(RD_DEPTH);
  localparam int CW   = PW + 1;
  logic [ID_W-1:0] rr_ptr, g;
  logic [ID_W-1:0] fifo [RD_DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic            err_orphan;
  logic            any, rd_g, wr_g, full, accept, push, pop, has;
  logic [N_REQ-1:0] pending;
  assign pending = bus.req_read | bus.req_write;
  // Scan downward so the index closest to rr_ptr is the last one to win.
  always_comb begin
    g   = '0;
    any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (pending[(int'(rr_ptr) + k) % N_REQ]) begin
        g   = ID_W'((int'(rr_ptr) + k) % N_REQ);
        any = 1'b1;
      end
  end
  assign rd_g   = any & bus.req_read[g];
  assign wr_g   = any & ~bus.req_read[g] & bus.req_write[g];
  assign full   = count == CW'(RD_DEPTH);
  assign has    = count != '0;
  assign bus.mem_read       = ~reset & rd_g & ~full;
  assign bus.mem_write      = ~reset & wr_g;
  assign bus.mem_addr       = any ? bus.req_addr[26*g +: 26] : '0;
  assign bus.mem_wr_strb    = any ? bus.req_wr_strb[2*g +: 2] : '0;
  assign bus.mem_data_write = any ? bus.req_data_write[16*g +: 16] : '0;
  assign accept = bus.mem_cmd_ready & (bus.mem_read | bus.mem_write);
  assign push   = accept & bus.mem_read;
  assign pop    = bus.mem_data_read_val & has;
  assign bus.req_ready   = accept ? N_REQ'(1) << g : '0;
  assign bus.rsp_val     = (~reset & pop) ? N_REQ'(1) << fifo[head] : '0;
  assign bus.rsp_data    = bus.mem_data_read;
  assign bus.outstanding = count;
  assign bus.err_orphan  = err_orphan;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rr_ptr     <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (accept) rr_ptr <= ID_W'((int'(g) + 1) % N_REQ);
      head  <= head + PW'(pop);
      tail  <= tail + PW'(push);
      count <= count + CW'(push) - CW'(pop);
      if (bus.mem_data_read_val & ~has) err_orphan <= 1'b1;
    end
  always_ff @(posedge clk)
    if (push) fifo[tail] <= g;
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Shares the single-command SDRAM controller port (read/write/addr/wr_strb/data_write, cmd_ready, data_read/data_read_val) between N_REQ requesters using round-robin arbitration.
- Each read the controller accepts is tagged with the ID of the requester that issued it, in an in-order tag FIFO.
- Each returning read word is routed back to the requester at the FIFO head.
- Sits between the SoC masters (CPU, video, DMA) and the SDRAM controller, in the same clock domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
RD_DEPTH, 8, max outstanding reads in the tag FIFO (power of two, >=2)
ID_W, $clog2(N_REQ), requester ID width (derived, do not override)

Ports:
clk  in  1  system clock (same clock as SDRAM controller)
reset  in  1  asynchronous, active-high reset
req_read  in  N_REQ  per-requester read request, held until accepted
req_write  in  N_REQ  per-requester write request, held until accepted
req_addr  in  N_REQ*26  per-requester address {chip,bank,row,col}; slice i = [26*i+:26]
req_wr_strb  in  N_REQ*2  per-requester byte strobes; slice i = [2*i+:2]
req_data_write  in  N_REQ*16  per-requester write data; slice i = [16*i+:16]
req_ready  out  N_REQ  one-hot accept; request i is taken on the clk edge where req_ready[i]=1
rsp_data  out  16  read data, broadcast to all requesters
rsp_val  out  N_REQ  one-hot read-data valid for the owning requester
mem_read  out  1  to controller read
mem_write  out  1  to controller write
mem_addr  out  26  to controller addr
mem_wr_strb  out  2  to controller wr_strb
mem_data_write  out  16  to controller data_write
mem_cmd_ready  in  1  from controller cmd_ready
mem_data_read  in  16  from controller data_read
mem_data_read_val  in  1  from controller data_read_val
outstanding  out  $clog2(RD_DEPTH)+1  reads issued but not yet returned
err_orphan  out  1  sticky: mem_data_read_val arrived with the tag FIFO empty

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- State: round-robin pointer rr_ptr (ID_W bits), tag FIFO (RD_DEPTH x ID_W, with head/tail/count), and err_orphan.
- Reset values: rr_ptr=0, FIFO empty, outstanding=0, err_orphan=0.
- While reset is asserted, all combinational outputs are 0: req_ready=0, rsp_val=0, mem_read=0, mem_write=0.
- Reset asserted mid-operation discards all in-flight tags; any later returning words raise err_orphan.
- Pending(i) = req_read[i] | req_write[i].
- Grant g = first pending index scanning rr_ptr, rr_ptr+1, ... modulo N_REQ. Purely combinational, no added latency.
- No requester pending: mem_read=0, mem_write=0, mem_addr=0, mem_wr_strb=0, mem_data_write=0.
- Otherwise the mem_* outputs carry requester g's fields.
- If req_read[g] and req_write[g] are both 1: the read wins. mem_write=0; the write stays pending, and the requester must drop req_read to issue it.
- Read blocking: if g wants a read and count==RD_DEPTH, forward nothing (mem_read=0, mem_write=0) and req_ready=0 for all.
  - A write from a lower-priority requester is NOT promoted in this case; the stall lasts until a pop.
- Accept: accept = mem_cmd_ready & (mem_read | mem_write). req_ready[g]=accept; all other bits 0.
- On an accept edge:
  - rr_ptr <= (g+1) mod N_REQ.
  - If mem_read: push g into the FIFO.
  - rr_ptr does not change when there is no accept.
- Response path:
  - rsp_data = mem_data_read, always.
  - rsp_val[head_id] = mem_data_read_val when FIFO is non-empty; all other bits 0.
  - On mem_data_read_val with FIFO non-empty: pop.
  - On mem_data_read_val with FIFO empty: rsp_val=0 and err_orphan<=1. err_orphan is cleared only by reset.
- Simultaneous push and pop: count unchanged, both pointers advance. The full check uses the current count only, with no pop bypass.
- Pointers wrap modulo RD_DEPTH. outstanding = count.
- Reads return in issue order, so per-requester ordering is preserved. Writes need no tag.

Test Plan:
- Single requester 1 issues a read at addr 0x0123456, controller returns 0xBEEF two cycles later -> req_ready=0b0010 for one cycle; rsp_val=0b0010 with rsp_data=0xBEEF; outstanding goes 0->1->0.
- Requesters 0-3 all hold writes, mem_cmd_ready held at 1 -> grants in order 0,1,2,3,0; each req_ready is one-hot for exactly one cycle per accept.
- Interleaved reads from 2 then 0, returns 0x1111 then 0x2222 -> rsp_val=0b0100 with 0x1111, then rsp_val=0b0001 with 0x2222.
- 8 reads issued with no returns (RD_DEPTH=8), then a 9th read request -> req_ready stays 0 and mem_read=0. After one mem_data_read_val, the 9th is accepted the next cycle; outstanding reads 8.
- Pulse mem_data_read_val with the FIFO empty -> rsp_val=0, err_orphan=1, and err_orphan stays 1 until reset.
- Assert reset asynchronously with 3 reads outstanding -> outputs go 0 immediately without waiting for a clk edge; outstanding=0 and rr_ptr=0 after release.
